// File: rtl/mult_seq_pkg.sv
// Shared types and step schedule for the sequential 8x8 multiplier built around a 4x4 core.
// Each operand is split into halves, and each step forms one half-product.
package mult_seq_pkg;

    localparam int unsigned MulWidth  = 4;
    localparam int unsigned OpWidth   = 2 * MulWidth;
    localparam int unsigned StepWidth = 2;

    typedef logic [StepWidth-1:0] step_t;

    localparam step_t StepLast = step_t'(3);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // shift_nib is the product shift counted in core-operand widths.
    typedef struct packed {
        logic       a_hi;
        logic       b_hi;
        logic [1:0] shift_nib;
    } step_cfg_t;

    function automatic step_cfg_t step_cfg(step_t step);
        step_cfg_t cfg;
        unique case (step)
            2'd0:    cfg = '{a_hi: 1'b0, b_hi: 1'b0, shift_nib: 2'd0};
            2'd1:    cfg = '{a_hi: 1'b0, b_hi: 1'b1, shift_nib: 2'd1};
            2'd2:    cfg = '{a_hi: 1'b1, b_hi: 1'b0, shift_nib: 2'd1};
            default: cfg = '{a_hi: 1'b1, b_hi: 1'b1, shift_nib: 2'd2};
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/mult_seq_pp_select.sv
// Step decoder: selects the operand halves fed to the core and the shift for the current step.
// The core operands are forced to zero when the decoder is disabled.
module mult_seq_pp_select
    import mult_seq_pkg::*;
#(
    parameter int unsigned MW     = MulWidth,
    parameter int unsigned W      = 2 * MW,
    parameter int unsigned ShiftW = $clog2(2 * W)
) (
    input  logic              en,
    input  logic [W-1:0]      op_a,
    input  logic [W-1:0]      op_b,
    input  step_t             step,
    output logic [MW-1:0]     mul_a,
    output logic [MW-1:0]     mul_b,
    output logic [ShiftW-1:0] shift
);

    step_cfg_t cfg;

    always_comb begin
        cfg   = step_cfg(step);
        mul_a = '0;
        mul_b = '0;
        shift = '0;
        if (en) begin
            mul_a = cfg.a_hi ? op_a[W-1:MW] : op_a[MW-1:0];
            mul_b = cfg.b_hi ? op_b[W-1:MW] : op_b[MW-1:0];
            shift = ShiftW'(cfg.shift_nib * MW);
        end
    end

endmodule

// File: rtl/mult8_seq_accumulator.sv
// 8x8 unsigned multiplier that reuses one external 4x4 combinational core over four cycles,
// with valid/ready handshakes on the operand input and the product output.
module mult8_seq_accumulator
    import mult_seq_pkg::*;
#(
    parameter int unsigned MW = MulWidth,
    parameter int unsigned W  = 2 * MW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    output logic [MW-1:0]   mul_a,
    output logic [MW-1:0]   mul_b,
    input  logic [2*MW-1:0] mul_p,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out_p,
    output logic            busy
);

    localparam int unsigned ShiftW = $clog2(2 * W);

    if (W != 2 * MW) begin : gen_width_check
        $error("mult8_seq_accumulator: W must equal 2*MW");
    end

    state_e           state_q, state_d;
    step_t            step_q, step_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [ShiftW-1:0] shift;
    logic [2*W-1:0]   pp_shifted;
    logic             accept;

    mult_seq_pp_select #(
        .MW    (MW),
        .W     (W),
        .ShiftW(ShiftW)
    ) u_pp_select (
        .en   (state_q == StRun),
        .op_a (a_q),
        .op_b (b_q),
        .step (step_q),
        .mul_a(mul_a),
        .mul_b(mul_b),
        .shift(shift)
    );

    assign pp_shifted = (2 * W)'(mul_p) << shift;

    // Gated by rst_n so nothing is accepted while reset is held.
    assign in_ready  = rst_n & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun);
    assign out_p     = acc_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        unique case (state_q)
            StIdle: ;
            StRun: begin
                acc_d  = acc_q + pp_shifted;
                step_d = step_q + step_t'(1);
                if (step_q == StepLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Accept covers both IDLE and the back-to-back DONE case.
        if (accept) begin
            a_d     = in_a;
            b_d     = in_b;
            acc_d   = '0;
            step_d  = '0;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_mult8_seq_accumulator.sv
// Self-checking bench: models the 4x4 core and checks products against plain a*b arithmetic.
// Covers reset, step schedule, backpressure, back-to-back, mid-operation reset and random ops.
module tb_mult8_seq_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Accept at edge T, out_valid after edge T+4: first seen on the 5th falling edge after T.
    localparam int LatNeg = 5;

    always #5 clk = ~clk;

    // Behavioural 4x4 core.
    assign mul_p = 8'(mul_a * mul_b);

    mult8_seq_accumulator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p    (out_p),
        .busy     (busy)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one operation; returns product, latency and flags for the caller to check.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall,
                          output logic [15:0] p, output int lat, output bit ok, output bit held);
        int guard;
        ok        = 1'b1;
        held      = 1'b1;
        lat       = 0;
        guard     = 0;
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) ok = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        if (!out_valid) ok = 1'b0;
        p = out_p;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (out_p !== p || out_valid !== 1'b1 || in_ready !== 1'b0) held = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, busy, in_ready} !== 3'b000) begin
            $display("FAIL reset_ctrl: got valid/busy/ready=%b want 000", {out_valid, busy, in_ready});
            n_fail++;
        end
        n_cmp++;
        if ({mul_a, mul_b, out_p} !== 24'h0) begin
            $display("FAIL reset_data: got mul_a=%h mul_b=%h out_p=%h want 0", mul_a, mul_b, out_p);
            n_fail++;
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
            n_fail++;
        end
    endtask

    task automatic test_zero();
        logic [15:0] p;
        int lat;
        bit ok, held;
        run_op(8'h00, 8'h00, 0, p, lat, ok, held);
        n_cmp++;
        if (!ok || p !== 16'h0000) begin
            $display("FAIL zero_product: got %h ok=%0d want 0000", p, ok);
            n_fail++;
        end
        n_cmp++;
        if (lat !== LatNeg) begin
            $display("FAIL zero_latency: got %0d want %0d", lat, LatNeg);
            n_fail++;
        end
    endtask

    task automatic test_schedule();
        logic [7:0] a, b;
        logic [3:0] exp_a[4];
        logic [3:0] exp_b[4];
        a = 8'h12;
        b = 8'h34;
        // Schedule from the half-product expansion a*b = alo*blo + (alo*bhi + ahi*blo)<<4 + ahi*bhi<<8.
        exp_a = '{a[3:0], a[3:0], a[7:4], a[7:4]};
        exp_b = '{b[3:0], b[7:4], b[3:0], b[7:4]};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 8'hEE;
        in_b     = 8'hEE;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            n_cmp++;
            if (mul_a !== exp_a[s] || mul_b !== exp_b[s] || busy !== 1'b1) begin
                $display("FAIL schedule_step%0d: got a=%h b=%h busy=%b want a=%h b=%h busy=1",
                         s, mul_a, mul_b, busy, exp_a[s], exp_b[s]);
                n_fail++;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_p !== 16'(a) * 16'(b)) begin
            $display("FAIL schedule_product: got valid=%b p=%h want 1 %h", out_valid, out_p,
                     16'(a) * 16'(b));
            n_fail++;
        end
        n_cmp++;
        if ({mul_a, mul_b, busy} !== 9'h0) begin
            $display("FAIL schedule_idle_core: got a=%h b=%h busy=%b want 0", mul_a, mul_b, busy);
            n_fail++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int guard;
        guard     = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'hFF;
        in_b      = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        do begin
            @(negedge clk);
            guard++;
        end while (!out_valid && guard < 20);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_p !== 16'hFE01 || in_ready !== 1'b0) begin
                $display("FAIL backpressure_hold%0d: got valid=%b p=%h ready=%b want 1 fe01 0",
                         i, out_valid, out_p, in_ready);
                n_fail++;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            $display("FAIL backpressure_ready_follow: got %b want 1", in_ready);
            n_fail++;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            $display("FAIL backpressure_release: got valid=%b want 0", out_valid);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a2, b2;
        int lat;
        a2        = 8'hA5;
        b2        = 8'h5A;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'h0F;
        in_b      = 8'h10;
        @(posedge clk);
        #1;
        in_a = a2;
        in_b = b2;
        repeat (LatNeg) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_p !== 16'h00F0) begin
            $display("FAIL b2b_first: got valid=%b ready=%b p=%h want 1 1 00f0",
                     out_valid, in_ready, out_p);
            n_fail++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || mul_a !== a2[3:0] || mul_b !== b2[3:0]) begin
            $display("FAIL b2b_no_bubble: got busy=%b valid=%b a=%h b=%h want 1 0 %h %h",
                     busy, out_valid, mul_a, mul_b, a2[3:0], b2[3:0]);
            n_fail++;
        end
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (out_p !== 16'(a2) * 16'(b2) || lat !== LatNeg) begin
            $display("FAIL b2b_second: got p=%h lat=%0d want %h %0d", out_p, lat,
                     16'(a2) * 16'(b2), LatNeg);
            n_fail++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int lat;
        bit ok, held;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'hC3;
        in_b      = 8'h3C;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, busy, in_ready, mul_a, mul_b} !== 11'h0) begin
            $display("FAIL midreset_async: got valid=%b busy=%b ready=%b a=%h b=%h want 0",
                     out_valid, busy, in_ready, mul_a, mul_b);
            n_fail++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL midreset_release: got ready=%b valid=%b want 1 0", in_ready, out_valid);
            n_fail++;
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL midreset_discard: got valid=%b busy=%b want 0 0", out_valid, busy);
            n_fail++;
        end
        run_op(8'h02, 8'h03, 0, p, lat, ok, held);
        n_cmp++;
        if (!ok || p !== 16'h0006) begin
            $display("FAIL midreset_next_op: got %h ok=%0d want 0006", p, ok);
            n_fail++;
        end
    endtask

    task automatic test_random();
        logic [7:0]  a, b;
        logic [15:0] p;
        int lat, stall;
        bit ok, held;
        logic [15:0] corners[6];
        corners = '{16'h00FF, 16'hFF00, 16'hFFFF, 16'h01FF, 16'h8080, 16'h0FF0};
        for (int i = 0; i < 1500; i++) begin
            if (i < 6) begin
                a = corners[i][15:8];
                b = corners[i][7:0];
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(a, b, stall, p, lat, ok, held);
            n_cmp++;
            if (!ok || p !== 16'(a) * 16'(b) || lat !== LatNeg || !held) begin
                $display("FAIL random_op%0d: %h*%h got p=%h lat=%0d ok=%0d held=%0d want %h %0d",
                         i, a, b, p, lat, ok, held, 16'(a) * 16'(b), LatNeg);
                n_fail++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_schedule();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
